// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified instruction/data memory controller.
package mem_pkg;

  typedef enum logic {
    CH_IF   = 1'b0,
    CH_DATA = 1'b1
  } ch_e;

  // Number of byte-address bits that select a byte inside one word.
  function automatic int word_off(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/unified_mem_ctrl_if.sv
// Fetch and data channel bundle between the core (master) and unified_mem_ctrl (slave).
interface unified_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_ready;
  logic                  if_valid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_ready;
  logic                  d_valid;
  logic [DATA_W-1:0]     d_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
    output if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
    input  if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata
  );
endinterface

// File: rtl/mem_array.sv
// Single-port word array: synchronous read, byte-enable write, read-before-write data out.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       en_i,
  input  logic                       we_i,
  input  logic [DATA_W/8-1:0]        be_i,
  input  logic [$clog2(DEPTH)-1:0]   idx_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o
);
  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately left out of reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[idx_i];
      if (we_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified memory front end: one-deep fetch/data request buffers, round-robin arbiter, valid strobes.
// Optional PERF_CNT_EN adds perf_access / perf_conflict counters.
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic                clk,
  input  logic                reset,
  unified_mem_ctrl_if.slave   bus
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]         perf_access,
  output logic [31:0]         perf_conflict
`endif
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF   = word_off(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);

  // DEPTH is a power of two, so truncating the word address is the modulo wrap.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(32'(a) >> OFF);
  endfunction

  logic              if_pend_q, if_pend_d;
  logic [ADDR_W-1:0] if_addr_q, if_addr_d;
  logic              d_pend_q, d_pend_d;
  logic              d_we_q, d_we_d;
  logic [BE_W-1:0]   d_be_q, d_be_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
  ch_e               last_q, last_d;
  logic              if_vld_q, d_vld_q;
  logic [DATA_W-1:0] if_hold_q, d_hold_q;

  logic              gnt_if, gnt_d;
  logic [DATA_W-1:0] arr_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_pend_q <= 1'b0;
      if_addr_q <= '0;
      d_pend_q  <= 1'b0;
      d_we_q    <= 1'b0;
      d_be_q    <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      last_q    <= CH_DATA;
      if_vld_q  <= 1'b0;
      d_vld_q   <= 1'b0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      if_pend_q <= if_pend_d;
      if_addr_q <= if_addr_d;
      d_pend_q  <= d_pend_d;
      d_we_q    <= d_we_d;
      d_be_q    <= d_be_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      last_q    <= last_d;
      if_vld_q  <= gnt_if;
      d_vld_q   <= gnt_d;
      if (if_vld_q) if_hold_q <= arr_rdata;
      if (d_vld_q)  d_hold_q  <= arr_rdata;
    end
  end

  // Fetch wins when alone, or on a conflict if data was granted last.
  always_comb begin
    gnt_if = if_pend_q && (!d_pend_q || last_q == CH_DATA);
    gnt_d  = d_pend_q && !gnt_if;
  end

  always_comb begin
    if_pend_d = if_pend_q;
    if_addr_d = if_addr_q;
    d_pend_d  = d_pend_q;
    d_we_d    = d_we_q;
    d_be_d    = d_be_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    last_d    = last_q;

    if (bus.if_req && !if_pend_q) begin
      if_pend_d = 1'b1;
      if_addr_d = bus.if_addr;
    end else if (gnt_if) begin
      if_pend_d = 1'b0;
    end

    if (bus.d_req && !d_pend_q) begin
      d_pend_d  = 1'b1;
      d_we_d    = bus.d_we;
      d_be_d    = bus.d_be;
      d_addr_d  = bus.d_addr;
      d_wdata_d = bus.d_wdata;
    end else if (gnt_d) begin
      d_pend_d = 1'b0;
    end

    if (gnt_if)     last_d = CH_IF;
    else if (gnt_d) last_d = CH_DATA;
  end

  mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .en_i    (gnt_if || gnt_d),
    .we_i    (gnt_d && d_we_q),
    .be_i    (d_be_q),
    .idx_i   (gnt_if ? word_idx(if_addr_q) : word_idx(d_addr_q)),
    .wdata_i (d_wdata_q),
    .rdata_o (arr_rdata)
  );

  // Array output is live only in the valid cycle; afterwards the held copy is shown.
  always_comb begin
    bus.if_ready = !if_pend_q;
    bus.if_valid = if_vld_q;
    bus.if_rdata = if_vld_q ? arr_rdata : if_hold_q;
    bus.d_ready  = !d_pend_q;
    bus.d_valid  = d_vld_q;
    bus.d_rdata  = d_vld_q ? arr_rdata : d_hold_q;
  end

`ifdef PERF_CNT_EN
  logic [31:0] perf_access_q, perf_conflict_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_access_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      if (gnt_if || gnt_d)       perf_access_q   <= perf_access_q + 32'd1;
      if (if_pend_q && d_pend_q) perf_conflict_q <= perf_conflict_q + 32'd1;
    end
  end

  assign perf_access   = perf_access_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: doc/unified_mem_ctrl.md
# unified_mem_ctrl

Parametrised single-port unified memory with a two-channel arbiter, placed between the processor core and storage. It replaces separate instruction and data memories with one array. An instruction-fetch channel (read-only) and a data channel (read/write, byte enables) each get a one-deep request buffer. A round-robin arbiter grants at most one access per cycle, and each channel returns data with a valid strobe.

## Interface
Parameters:
- DATA_W, 32, word width in bits; multiple of 8
- ADDR_W, 8, byte-address width of both channels
- DEPTH, 64, number of words in the array; power of two

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request strobe, accepted when if_ready=1
- if_addr  in  ADDR_W  fetch byte address
- if_ready  out  1  fetch buffer empty
- if_valid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  DATA_W  fetched word
- d_req  in  1  data request strobe, accepted when d_ready=1
- d_we  in  1  1 = write, 0 = read
- d_be  in  DATA_W/8  byte enables for writes
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  write data
- d_ready  out  1  data buffer empty
- d_valid  out  1  data access complete, one-cycle pulse
- d_rdata  out  DATA_W  word read (pre-write contents on writes)

## Operation
- Each channel has a pending bit plus captured request fields. A strobe with ready=1 sets pending and captures addr/we/be/wdata. A strobe with ready=0 is ignored. ready = !pending.
- Word index = addr[ADDR_W-1 : log2(DATA_W/8)] modulo DEPTH. Low byte-address bits are ignored. Out-of-range addresses wrap.
- Arbiter, evaluated each cycle on the pending bits:
  - Only one channel pending: that channel is granted.
  - Both channels pending: the channel not granted last time wins.
  - last_grant resets to DATA, so fetch wins the first conflict.
- Granted access:
  - The array is read, and written for d_we=1, at the grant edge.
  - Bytes with d_be[i]=1 are written. d_be=0 with d_we=1 writes nothing but still completes.
  - The channel's pending bit clears.
- The fetch channel never writes.
- Array contents are not initialised and not affected by reset.
- Reset values: pending=0, if_ready=d_ready=1, if_valid=d_valid=0, if_rdata=d_rdata=0, last_grant=DATA.
- Reset mid-operation: ungranted pending requests are dropped and no write occurs. A write committed at an earlier edge persists.

## Timing
- Strobe accepted at edge E. The earliest grant is cycle E+1, with the array accessed at edge E+1. valid=1 and rdata are presented during cycle E+2.
- ready returns to 1 in the cycle after the grant edge, the same cycle as valid. A new strobe can be accepted then.
- A single channel sustains one request every two cycles.
- Both channels together keep the array busy every cycle.
- A deferred channel waits exactly one extra cycle. Starvation is impossible.
- rdata holds its value until the channel's next valid.
- A strobe in the same cycle as valid for that channel is accepted (ready=1).
- A read and a write to the same word, granted back-to-back, see the write in order.

## Configuration
- PERF_CNT_EN defined:
  - Adds outputs perf_access (32-bit count of granted accesses) and perf_conflict (32-bit count of cycles where both channels are pending).
  - Both counters wrap at 2^32 and reset to 0.
- PERF_CNT_EN undefined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- Package mem_pkg holds:
  - the channel-id typedef (CH_IF, CH_DATA) for last_grant;
  - the word-offset helper constant log2(DATA_W/8).
- Sub-module mem_array holds the DEPTH×DATA_W storage. It has a synchronous read, a byte-enable write and read-before-write output.
- unified_mem_ctrl holds the request buffers, arbiter, valid logic and optional counters.

## Test plan
- Reset, then data write addr 0x04, be=4'b1111, wdata=0xDEADBEEF → d_valid two cycles after the strobe. Fetch of 0x04 then returns if_rdata=0xDEADBEEF.
- Partial write 0x04, be=4'b0010, wdata=0x0000AA00 → a later data read of 0x04 returns 0xDEADAABE... wait: the read returns 0xDEADAAEF.
- Both channels strobed in the same cycle, repeatedly for 8 rounds:
  - first grant goes to fetch, then grants alternate;
  - each channel completes 8 accesses;
  - with PERF_CNT_EN, perf_conflict=8.
- Strobe while ready=0 → ignored, with no extra valid. Address 0x100+4 with ADDR_W=10 and DEPTH=64 wraps to word 1.
- Assert reset with both channels pending → no valids, the array is unchanged and ready=1 after reset is released.
